// File: rtl/aes_word_loader.sv
// Assembles one AES cipher key and 128-bit plaintext blocks from a 32-bit word stream.
// Define AES_LOADER_BLKCNT_EN to add the saturating blk_count output.
module aes_word_loader #(
  parameter int KEY_WORDS = 4,
  parameter int KEY_W     = 32 * KEY_WORDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             key_reload,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [127:0]     blk_data,
  output logic [KEY_W-1:0] blk_key,
`ifdef AES_LOADER_BLKCNT_EN
  output logic [15:0]      blk_count,
`endif
  output logic             key_loaded
);

  if (!(KEY_WORDS == 4 || KEY_WORDS == 6 || KEY_WORDS == 8) || KEY_W != 32 * KEY_WORDS) begin : g_bad_param
    $error("aes_word_loader: KEY_WORDS must be 4, 6 or 8 and KEY_W must equal 32*KEY_WORDS");
  end

  typedef enum logic [1:0] {
    LOAD_KEY,
    LOAD_DATA,
    PRESENT
  } state_e;

  localparam logic [2:0] KEY_LAST  = 3'(KEY_WORDS - 1);
  localparam logic [2:0] DATA_LAST = 3'd3;

  state_e             state_q;
  logic [2:0]         cnt_q;
  logic [2:0]         cnt_d;
  logic               reloadPending_q;
  logic               inReady_q;
  logic               blkValid_q;
  logic               keyLoaded_q;
  logic [127:0]       blkData_q;
  logic [KEY_W-1:0]   blkKey_q;
  logic               accept;
`ifdef AES_LOADER_BLKCNT_EN
  logic [15:0]        blkCount_q;
`endif

  assign accept = in_valid & inReady_q;
  assign cnt_d  = cnt_q + 3'd1;

  // in_ready is registered from the next state, so it is 0 in reset and in PRESENT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= LOAD_KEY;
      cnt_q           <= '0;
      reloadPending_q <= 1'b0;
      inReady_q       <= 1'b0;
      blkValid_q      <= 1'b0;
      keyLoaded_q     <= 1'b0;
      blkData_q       <= '0;
      blkKey_q        <= '0;
`ifdef AES_LOADER_BLKCNT_EN
      blkCount_q      <= '0;
`endif
    end else begin
      case (state_q)
        LOAD_KEY: begin
          inReady_q <= 1'b1;
          if (key_reload) reloadPending_q <= 1'b1;
          if (accept) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
              if (cnt_q == 3'(i)) blkKey_q[KEY_W-1-32*i -: 32] <= in_data;
            end
            if (cnt_q == KEY_LAST) begin
              cnt_q       <= '0;
              keyLoaded_q <= 1'b1;
              state_q     <= LOAD_DATA;
`ifdef AES_LOADER_BLKCNT_EN
              blkCount_q  <= '0;
`endif
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        LOAD_DATA: begin
          inReady_q <= 1'b1;
          if (key_reload) reloadPending_q <= 1'b1;
          if (accept) begin
            for (int i = 0; i < 4; i++) begin
              if (cnt_q == 3'(i)) blkData_q[127-32*i -: 32] <= in_data;
            end
            if (cnt_q == DATA_LAST) begin
              cnt_q      <= '0;
              state_q    <= PRESENT;
              inReady_q  <= 1'b0;
              blkValid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        PRESENT: begin
          // a reload seen while the block waits is kept rather than dropped
          if (blk_ready) begin
            blkValid_q      <= 1'b0;
            inReady_q       <= 1'b1;
            reloadPending_q <= 1'b0;
            state_q         <= (reloadPending_q | key_reload) ? LOAD_KEY : LOAD_DATA;
`ifdef AES_LOADER_BLKCNT_EN
            if (blkCount_q != 16'hFFFF) blkCount_q <= blkCount_q + 16'd1;
`endif
          end else if (key_reload) begin
            reloadPending_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= LOAD_KEY;
          cnt_q     <= '0;
          inReady_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = inReady_q;
  assign blk_valid  = blkValid_q;
  assign blk_data   = blkData_q;
  assign blk_key    = blkKey_q;
  assign key_loaded = keyLoaded_q;
`ifdef AES_LOADER_BLKCNT_EN
  assign blk_count  = blkCount_q;
`endif

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader: directed key/data scenarios plus randomized
// gaps, stalls and reload points checked against a word-concatenation reference model.
module tb_aes_word_loader;

`ifdef AES_LOADER_BLKCNT_EN
  localparam int KW = 8;
`else
  localparam int KW = 4;
`endif
  localparam int KEYW = 32 * KW;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_data;
  logic            key_reload;
  logic            blk_valid;
  logic            blk_ready;
  logic [127:0]    blk_data;
  logic [KEYW-1:0] blk_key;
  logic            key_loaded;
`ifdef AES_LOADER_BLKCNT_EN
  logic [15:0]     blk_count;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  logic [255:0] modelKey;
  logic [127:0] modelData;
  int           modelCount;

  aes_word_loader #(.KEY_WORDS(KW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .key_reload (key_reload),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .blk_key    (blk_key),
`ifdef AES_LOADER_BLKCNT_EN
    .blk_count  (blk_count),
`endif
    .key_loaded (key_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // every comparison in the bench funnels through here so the counts stay honest
  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // the reference model: a group is just its words concatenated, first word in the MSBs
  function automatic logic [255:0] packWords(input logic [31:0] w[8], input int n);
    logic [255:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) acc = (acc << 32) | 256'(w[i]);
    return acc;
  endfunction

  // drive one word and return right after the rising edge that accepts it
  task automatic applyStimulus(input logic [31:0] word, input int gap, input logic reload);
    int waitCnt;
    repeat (gap) begin
      @(negedge clk);
      in_valid   = 1'b0;
      key_reload = 1'b0;
    end
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = word;
    key_reload = reload;
    waitCnt    = 0;
    while (in_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 50) checkOutput("inReadyTimeout", 256'(in_ready), 256'(1));
    @(posedge clk);
  endtask

  task automatic sendKey(input logic [31:0] w[8], input int maxGap);
    for (int i = 0; i < KW; i++) applyStimulus(w[i], $urandom_range(0, maxGap), 1'b0);
    modelKey   = packWords(w, KW);
    modelCount = 0;
    #1;
    checkOutput("keyLoadedSet", 256'(key_loaded), 256'(1));
    checkOutput("validDuringKey", 256'(blk_valid), 256'(0));
`ifdef AES_LOADER_BLKCNT_EN
    checkOutput("blkCountClear", 256'(blk_count), 256'(0));
`endif
  endtask

  task automatic sendData(input logic [31:0] w[8], input int maxGap, input int reloadIdx);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(w[i], $urandom_range(0, maxGap), (i == reloadIdx));
      if (i == 2) begin
        #1;
        checkOutput("validBeforeLast", 256'(blk_valid), 256'(0));
      end
    end
    modelData = 128'(packWords(w, 4));
    #1;
    checkOutput("validLatency", 256'(blk_valid), 256'(1));
  endtask

  task automatic takeBlock(input int stall, input logic reloadAtHs);
    int n;
    n = 0;
    @(negedge clk);
    while (blk_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("blkValid", 256'(blk_valid), 256'(1));
    checkOutput("blkKey", 256'(blk_key), modelKey);
    checkOutput("blkData", 256'(blk_data), 256'(modelData));
    checkOutput("keyLoaded", 256'(key_loaded), 256'(1));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("stallInReady", 256'(in_ready), 256'(0));
      checkOutput("stallValid", 256'(blk_valid), 256'(1));
      checkOutput("stallData", 256'(blk_data), 256'(modelData));
      checkOutput("stallKey", 256'(blk_key), modelKey);
    end
    @(negedge clk);
    blk_ready  = 1'b1;
    key_reload = reloadAtHs;
    in_valid   = 1'b0;
    @(negedge clk);
    blk_ready  = 1'b0;
    key_reload = 1'b0;
    modelCount = (modelCount < 65535) ? modelCount + 1 : modelCount;
    checkOutput("validDrop", 256'(blk_valid), 256'(0));
    checkOutput("inReadyAfter", 256'(in_ready), 256'(1));
`ifdef AES_LOADER_BLKCNT_EN
    checkOutput("blkCount", 256'(blk_count), 256'(modelCount));
`endif
  endtask

  task automatic randomWords(output logic [31:0] w[8]);
    for (int i = 0; i < 8; i++) w[i] = $urandom;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "InReady"}, 256'(in_ready), 256'(0));
    checkOutput({tag, "Valid"}, 256'(blk_valid), 256'(0));
    checkOutput({tag, "Key"}, 256'(blk_key), 256'(0));
    checkOutput({tag, "Data"}, 256'(blk_data), 256'(0));
    checkOutput({tag, "KeyLoaded"}, 256'(key_loaded), 256'(0));
`ifdef AES_LOADER_BLKCNT_EN
    checkOutput({tag, "Count"}, 256'(blk_count), 256'(0));
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] keyA[8];
    logic [31:0] keyB[8];
    logic [31:0] dataA[8];
    logic [31:0] w[8];
    int          mode;
    logic        pendingKey;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    key_reload = 1'b0;
    blk_ready  = 1'b0;
    modelKey   = '0;
    modelData  = '0;
    modelCount = 0;
    keyA  = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
              32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f};
    keyB  = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
              32'h762e7160, 32'hf38b4da5, 32'h6a784d90, 32'h45190cfe};
    dataA = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
              32'h0, 32'h0, 32'h0, 32'h0};

    #2;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed block 1 with 10-cycle back-pressure");
    sendKey(keyA, 0);
    sendData(dataA, 0, -1);
    takeBlock(10, 1'b0);

    $display("[TB] block 2 with reload on its 2nd data word");
    randomWords(w);
    sendData(w, 0, 1);
    takeBlock(0, 1'b0);
    sendKey(keyB, 0);
    randomWords(w);
    sendData(w, 0, -1);
    takeBlock(2, 1'b1);

    $display("[TB] reload together with the handshake");
    randomWords(w);
    sendKey(w, 0);
    randomWords(w);
    sendData(w, 0, -1);
    takeBlock(0, 1'b0);

    $display("[TB] randomized gaps, stalls and reload points");
    pendingKey = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (pendingKey) begin
        randomWords(w);
        sendKey(w, 1);
      end
      mode = (b == 7) ? 2 : int'($urandom_range(0, 2));
      randomWords(w);
      sendData(w, 1, (mode == 1) ? int'($urandom_range(0, 3)) : -1);
      takeBlock($urandom_range(0, 3), (mode == 2));
      pendingKey = (mode != 0);
    end

    $display("[TB] reset after two data words");
    randomWords(w);
    sendKey(w, 1);
    applyStimulus($urandom, 0, 1'b0);
    applyStimulus($urandom, 0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkAllZero("midReset");
    modelCount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    randomWords(w);
    sendKey(w, 1);
    randomWords(w);
    sendData(w, 1, -1);
    takeBlock(1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
